// File: rtl/atm_session_ctrl.sv
// ATM session controller: one-hot session FSM with verifier handshake,
// PIN lockout, inactivity timeout and EXIT-edge abort.
//
// state                    | meaning
// -------------------------+--------------------------------------------
// S_IDLE                   | no session; waits for a key press
// S_ACC_NUM                | entering account number
// S_PIN_INPUT              | entering PIN
// S_MENU                   | main menu, choice on usr_input
// S_SHOW_BALANCES          | balance display, any key returns to menu
// S_CONVERT_1              | conversion: source currency
// S_CONVERT_2              | conversion: target currency
// S_SELECT_AMOUNT_WITHDRAW | withdraw amount entry
// S_TRANSFER               | transfer: destination account entry
// S_SELECT_CURRENCY_XFER   | transfer: currency selection
// S_SELECT_AMOUNT_XFER     | transfer: amount entry
// S_SUCCESS                | timed dwell, then back to menu
// S_ERROR                  | timed dwell, then back to idle
module atm_session_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_PIN_TRIES  = 3,
    parameter int HOLD_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [3:0]  status_code,
    input  logic [1:0]  usr_input,
    input  logic        vdone,
    input  logic        vok,
    output logic [15:0] current_state,
    output logic [3:0]  input_style,
    output logic        vreq,
    output logic [1:0]  vkind,
    output logic        busy,
    output logic        locked,
    output logic        timeout,
    output logic [1:0]  pin_tries_left
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [1:0]    TRIES_MAX  = 2'(MAX_PIN_TRIES);
    localparam logic [3:0]    EXIT_CODE  = 4'b0111;

    localparam logic [1:0] K_ACCOUNT = 2'b00;
    localparam logic [1:0] K_PIN     = 2'b01;
    localparam logic [1:0] K_AMOUNT  = 2'b10;

    typedef enum logic [15:0] {
        S_IDLE                   = 16'h0001,
        S_ACC_NUM                = 16'h0002,
        S_PIN_INPUT              = 16'h0004,
        S_MENU                   = 16'h0008,
        S_SHOW_BALANCES          = 16'h0010,
        S_CONVERT_1              = 16'h0020,
        S_CONVERT_2              = 16'h0040,
        S_SELECT_AMOUNT_WITHDRAW = 16'h0080,
        S_TRANSFER               = 16'h0100,
        S_SELECT_CURRENCY_XFER   = 16'h0200,
        S_SELECT_AMOUNT_XFER     = 16'h0400,
        S_SUCCESS                = 16'h0800,
        S_ERROR                  = 16'h1000
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_vreq;
    logic [1:0]      r_vkind;
    logic            r_locked;
    logic            r_timeout;
    logic [1:0]      r_tries;
    logic [TW-1:0]   r_timer;
    logic [HW-1:0]   r_hold;
    logic            r_exit_q;

    state_t          w_state_nxt;
    logic            w_busy_nxt;
    logic            w_vreq_nxt;
    logic [1:0]      w_vkind_nxt;
    logic            w_locked_nxt;
    logic            w_timeout_nxt;
    logic [1:0]      w_tries_nxt;
    logic [TW-1:0]   w_timer_nxt;
    logic [HW-1:0]   w_hold_nxt;
    logic [1:0]      w_tries_dec;

    logic w_exit;
    logic w_abort;
    logic w_event;
    logic w_in_hold;
    logic w_counting;

    assign w_exit     = (status_code == EXIT_CODE);
    assign w_abort    = w_exit && !r_exit_q;
    assign w_event    = ready && !r_busy;
    assign w_in_hold  = (r_state == S_SUCCESS) || (r_state == S_ERROR);
    assign w_counting = !r_busy && (r_state != S_IDLE) && !w_in_hold;
    assign w_tries_dec = r_tries - 2'd1;

    // State and session registers; every next value comes from the decode below.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_vreq    <= 1'b0;
            r_vkind   <= 2'b00;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
            r_tries   <= TRIES_MAX;
            r_timer   <= '0;
            r_hold    <= HOLD_LAST;
            r_exit_q  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= w_busy_nxt;
            r_vreq    <= w_vreq_nxt;
            r_vkind   <= w_vkind_nxt;
            r_locked  <= w_locked_nxt;
            r_timeout <= w_timeout_nxt;
            r_tries   <= w_tries_nxt;
            r_timer   <= w_timer_nxt;
            r_hold    <= w_hold_nxt;
            r_exit_q  <= w_exit;
        end
    end

    // Next-state decode: abort beats verifier response, which beats keypad events and timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_busy_nxt    = r_busy;
        w_vreq_nxt    = 1'b0;
        w_vkind_nxt   = r_vkind;
        w_locked_nxt  = r_locked;
        w_timeout_nxt = 1'b0;
        w_tries_nxt   = r_tries;
        w_timer_nxt   = r_timer;
        w_hold_nxt    = HOLD_LAST;

        if (w_in_hold) begin
            w_hold_nxt = (r_hold == '0) ? r_hold : r_hold - HW'(1);
        end

        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
        end else if (r_busy) begin
            if (vdone) begin
                w_busy_nxt = 1'b0;
                case (r_state)
                    S_ACC_NUM:   w_state_nxt = vok ? S_PIN_INPUT : S_ERROR;
                    S_TRANSFER:  w_state_nxt = vok ? S_SELECT_CURRENCY_XFER : S_ERROR;
                    S_PIN_INPUT: begin
                        if (vok) begin
                            w_state_nxt = S_MENU;
                            w_tries_nxt = TRIES_MAX;
                        end else begin
                            w_tries_nxt = w_tries_dec;
                            if (w_tries_dec == 2'd0) begin
                                w_state_nxt  = S_ERROR;
                                w_locked_nxt = 1'b1;
                            end
                        end
                    end
                    S_SELECT_AMOUNT_WITHDRAW,
                    S_SELECT_AMOUNT_XFER: w_state_nxt = vok ? S_SUCCESS : S_ERROR;
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end else begin
            case (r_state)
                S_IDLE: if (w_event && !r_locked) w_state_nxt = S_ACC_NUM;
                S_ACC_NUM, S_TRANSFER: if (w_event) begin
                    w_vreq_nxt  = 1'b1;
                    w_vkind_nxt = K_ACCOUNT;
                    w_busy_nxt  = 1'b1;
                end
                S_PIN_INPUT: if (w_event) begin
                    w_vreq_nxt  = 1'b1;
                    w_vkind_nxt = K_PIN;
                    w_busy_nxt  = 1'b1;
                end
                S_SELECT_AMOUNT_WITHDRAW, S_SELECT_AMOUNT_XFER: if (w_event) begin
                    w_vreq_nxt  = 1'b1;
                    w_vkind_nxt = K_AMOUNT;
                    w_busy_nxt  = 1'b1;
                end
                S_MENU: if (w_event) begin
                    case (usr_input)
                        2'b00:   w_state_nxt = S_SHOW_BALANCES;
                        2'b01:   w_state_nxt = S_CONVERT_1;
                        2'b10:   w_state_nxt = S_SELECT_AMOUNT_WITHDRAW;
                        default: w_state_nxt = S_TRANSFER;
                    endcase
                end
                S_SHOW_BALANCES:        if (w_event) w_state_nxt = S_MENU;
                S_CONVERT_1:            if (w_event) w_state_nxt = S_CONVERT_2;
                S_CONVERT_2:            if (w_event) w_state_nxt = S_SUCCESS;
                S_SELECT_CURRENCY_XFER: if (w_event) w_state_nxt = S_SELECT_AMOUNT_XFER;
                S_SUCCESS:              if (r_hold == '0) w_state_nxt = S_MENU;
                S_ERROR:                if (r_hold == '0) w_state_nxt = S_IDLE;
                default:                w_state_nxt = S_IDLE;
            endcase

            if (w_counting && !w_event && (r_timer == TIMER_LAST)) begin
                w_state_nxt   = S_IDLE;
                w_timeout_nxt = 1'b1;
            end
        end

        // Inactivity timer holds its value across a pending verification.
        if (w_abort) begin
            w_timer_nxt = '0;
        end else if (r_busy) begin
            w_timer_nxt = r_timer;
        end else if (!w_counting || w_event || (w_state_nxt != r_state)) begin
            w_timer_nxt = '0;
        end else begin
            w_timer_nxt = r_timer + TW'(1);
        end

        // A fresh session always starts with the full PIN budget unless locked out.
        if ((w_state_nxt == S_IDLE) && (r_state != S_IDLE) && !w_locked_nxt) begin
            w_tries_nxt = TRIES_MAX;
        end
    end

    // Keypad mode follows the current state.
    always_comb begin
        input_style = 4'b0001;
        case (r_state)
            S_ACC_NUM, S_TRANSFER:                          input_style = 4'b0010;
            S_PIN_INPUT:                                    input_style = 4'b0011;
            S_MENU:                                         input_style = 4'b0100;
            S_CONVERT_1, S_CONVERT_2, S_SELECT_CURRENCY_XFER: input_style = 4'b0101;
            S_SELECT_AMOUNT_WITHDRAW, S_SELECT_AMOUNT_XFER: input_style = 4'b0110;
            default:                                        input_style = 4'b0001;
        endcase
    end

    assign current_state  = r_state;
    assign vreq           = r_vreq;
    assign vkind          = r_vkind;
    assign busy           = r_busy;
    assign locked         = r_locked;
    assign timeout        = r_timeout;
    assign pin_tries_left = r_tries;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl with a short inactivity timeout.
module tb_atm_session_ctrl;

    logic        clk;
    logic        rst;
    logic        ready;
    logic [3:0]  status_code;
    logic [1:0]  usr_input;
    logic        vdone;
    logic        vok;
    logic [15:0] current_state;
    logic [3:0]  input_style;
    logic        vreq;
    logic [1:0]  vkind;
    logic        busy;
    logic        locked;
    logic        timeout;
    logic [1:0]  pin_tries_left;

    int n_vec = 0;
    int n_err = 0;

    atm_session_ctrl #(
        .TIMEOUT_CYCLES(8),
        .MAX_PIN_TRIES (3),
        .HOLD_CYCLES   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ready         (ready),
        .status_code   (status_code),
        .usr_input     (usr_input),
        .vdone         (vdone),
        .vok           (vok),
        .current_state (current_state),
        .input_style   (input_style),
        .vreq          (vreq),
        .vkind         (vkind),
        .busy          (busy),
        .locked        (locked),
        .timeout       (timeout),
        .pin_tries_left(pin_tries_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; ready = 1'b0; status_code = 4'b0000;
        usr_input = 2'b00; vdone = 1'b0; vok = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic press();
        ready = 1'b1; tick(); ready = 1'b0;
    endtask

    task automatic respond(input logic ok);
        vdone = 1'b1; vok = ok; tick(); vdone = 1'b0; vok = 1'b0;
    endtask

    task automatic goto_menu();
        press(); press(); respond(1'b1);
        press(); respond(1'b1);
        if (current_state !== 16'h0008) begin n_err++; $display("FAIL goto_menu state got %h exp %h", current_state, 16'h0008); end
        n_vec++;
    endtask

    task automatic test_reset();
        do_reset();
        if (current_state !== 16'h0001) begin n_err++; $display("FAIL rst_state got %h exp %h", current_state, 16'h0001); end
        n_vec++;
        if (input_style !== 4'b0001) begin n_err++; $display("FAIL rst_style got %b exp %b", input_style, 4'b0001); end
        n_vec++;
        if ({vreq, vkind, busy, locked, timeout} !== 6'b0) begin n_err++; $display("FAIL rst_flags got %b exp %b", {vreq, vkind, busy, locked, timeout}, 6'b0); end
        n_vec++;
        if (pin_tries_left !== 2'd3) begin n_err++; $display("FAIL rst_tries got %0d exp %0d", pin_tries_left, 3); end
        n_vec++;
    endtask

    task automatic test_happy_path();
        do_reset();
        press();
        if (current_state !== 16'h0002 || input_style !== 4'b0010) begin n_err++; $display("FAIL happy_acc got %h/%b exp 0002/0010", current_state, input_style); end
        n_vec++;
        press();
        if ({vreq, vkind, busy} !== 4'b1001 || current_state !== 16'h0002) begin n_err++; $display("FAIL happy_vreq_acc got %b/%h exp 1001/0002", {vreq, vkind, busy}, current_state); end
        n_vec++;
        press();
        if (vreq !== 1'b0 || busy !== 1'b1 || current_state !== 16'h0002) begin n_err++; $display("FAIL busy_ignores_ready got vreq=%b busy=%b st=%h exp 0/1/0002", vreq, busy, current_state); end
        n_vec++;
        respond(1'b1);
        if (current_state !== 16'h0004 || busy !== 1'b0 || input_style !== 4'b0011) begin n_err++; $display("FAIL happy_pin got %h/%b/%b exp 0004/0/0011", current_state, busy, input_style); end
        n_vec++;
        press();
        if ({vreq, vkind, busy} !== 4'b1011) begin n_err++; $display("FAIL happy_vreq_pin got %b exp 1011", {vreq, vkind, busy}); end
        n_vec++;
        respond(1'b1);
        if (current_state !== 16'h0008 || pin_tries_left !== 2'd3 || input_style !== 4'b0100) begin n_err++; $display("FAIL happy_menu got %h/%0d/%b exp 0008/3/0100", current_state, pin_tries_left, input_style); end
        n_vec++;
        respond(1'b1);
        if (current_state !== 16'h0008 || busy !== 1'b0) begin n_err++; $display("FAIL stray_vdone got %h/%b exp 0008/0", current_state, busy); end
        n_vec++;
    endtask

    task automatic test_lockout();
        logic [1:0]  exp_tries [3] = '{2'd2, 2'd1, 2'd0};
        logic [15:0] exp_state [3] = '{16'h0004, 16'h0004, 16'h1000};
        do_reset();
        press(); press(); respond(1'b1);
        for (int i = 0; i < 3; i++) begin
            press();
            respond(1'b0);
            if (pin_tries_left !== exp_tries[i] || current_state !== exp_state[i]) begin n_err++; $display("FAIL lock_try%0d got %0d/%h exp %0d/%h", i, pin_tries_left, current_state, exp_tries[i], exp_state[i]); end
            n_vec++;
        end
        if (locked !== 1'b1) begin n_err++; $display("FAIL lock_flag got %b exp 1", locked); end
        n_vec++;
        press(); tick(); tick();
        if (current_state !== 16'h1000) begin n_err++; $display("FAIL lock_err_hold got %h exp 1000", current_state); end
        n_vec++;
        tick();
        if (current_state !== 16'h0001 || locked !== 1'b1 || pin_tries_left !== 2'd0) begin n_err++; $display("FAIL lock_idle got %h/%b/%0d exp 0001/1/0", current_state, locked, pin_tries_left); end
        n_vec++;
        press(); press();
        if (current_state !== 16'h0001) begin n_err++; $display("FAIL lock_ignore got %h exp 0001", current_state); end
        n_vec++;
    endtask

    task automatic test_withdraw();
        do_reset();
        goto_menu();
        usr_input = 2'b10;
        press();
        if (current_state !== 16'h0080 || input_style !== 4'b0110) begin n_err++; $display("FAIL wd_state got %h/%b exp 0080/0110", current_state, input_style); end
        n_vec++;
        press();
        if ({vreq, vkind, busy} !== 4'b1101) begin n_err++; $display("FAIL wd_vreq got %b exp 1101", {vreq, vkind, busy}); end
        n_vec++;
        respond(1'b0);
        if (current_state !== 16'h1000 || input_style !== 4'b0001 || locked !== 1'b0) begin n_err++; $display("FAIL wd_error got %h/%b/%b exp 1000/0001/0", current_state, input_style, locked); end
        n_vec++;
        tick(); tick(); tick();
        if (current_state !== 16'h1000) begin n_err++; $display("FAIL wd_hold got %h exp 1000", current_state); end
        n_vec++;
        tick();
        if (current_state !== 16'h0001 || pin_tries_left !== 2'd3) begin n_err++; $display("FAIL wd_idle got %h/%0d exp 0001/3", current_state, pin_tries_left); end
        n_vec++;
    endtask

    task automatic test_convert();
        do_reset();
        goto_menu();
        usr_input = 2'b01;
        press();
        if (current_state !== 16'h0020 || input_style !== 4'b0101) begin n_err++; $display("FAIL cv1 got %h/%b exp 0020/0101", current_state, input_style); end
        n_vec++;
        press();
        if (current_state !== 16'h0040) begin n_err++; $display("FAIL cv2 got %h exp 0040", current_state); end
        n_vec++;
        press();
        if (current_state !== 16'h0800 || input_style !== 4'b0001) begin n_err++; $display("FAIL cv_success got %h/%b exp 0800/0001", current_state, input_style); end
        n_vec++;
        press(); tick(); tick();
        if (current_state !== 16'h0800) begin n_err++; $display("FAIL cv_hold got %h exp 0800", current_state); end
        n_vec++;
        tick();
        if (current_state !== 16'h0008) begin n_err++; $display("FAIL cv_back_menu got %h exp 0008", current_state); end
        n_vec++;
    endtask

    task automatic test_transfer();
        do_reset();
        goto_menu();
        usr_input = 2'b11;
        press(); press(); respond(1'b1);
        if (current_state !== 16'h0200 || input_style !== 4'b0101) begin n_err++; $display("FAIL xf_cur got %h/%b exp 0200/0101", current_state, input_style); end
        n_vec++;
        press();
        if (current_state !== 16'h0400 || input_style !== 4'b0110) begin n_err++; $display("FAIL xf_amt got %h/%b exp 0400/0110", current_state, input_style); end
        n_vec++;
        press();
        if ({vreq, vkind, busy} !== 4'b1101) begin n_err++; $display("FAIL xf_vreq got %b exp 1101", {vreq, vkind, busy}); end
        n_vec++;
        respond(1'b1);
        if (current_state !== 16'h0800) begin n_err++; $display("FAIL xf_success got %h exp 0800", current_state); end
        n_vec++;
    endtask

    task automatic test_abort_race();
        do_reset();
        goto_menu();
        usr_input = 2'b11;
        press();
        if (current_state !== 16'h0100 || input_style !== 4'b0010) begin n_err++; $display("FAIL ab_transfer got %h/%b exp 0100/0010", current_state, input_style); end
        n_vec++;
        status_code = 4'b1000;
        press();
        if ({vreq, vkind, busy} !== 4'b1001) begin n_err++; $display("FAIL ab_vreq got %b exp 1001", {vreq, vkind, busy}); end
        n_vec++;
        status_code = 4'b0111;
        respond(1'b1);
        if (current_state !== 16'h0001 || busy !== 1'b0) begin n_err++; $display("FAIL ab_race got %h/%b exp 0001/0", current_state, busy); end
        n_vec++;
        repeat (10) tick();
        if (current_state !== 16'h0001 || busy !== 1'b0) begin n_err++; $display("FAIL ab_held got %h/%b exp 0001/0", current_state, busy); end
        n_vec++;
        press();
        if (current_state !== 16'h0002) begin n_err++; $display("FAIL ab_no_retrigger got %h exp 0002", current_state); end
        n_vec++;
        status_code = 4'b0000;
    endtask

    task automatic test_timeout();
        do_reset();
        goto_menu();
        repeat (7) tick();
        if (current_state !== 16'h0008 || timeout !== 1'b0) begin n_err++; $display("FAIL to_before got %h/%b exp 0008/0", current_state, timeout); end
        n_vec++;
        tick();
        if (current_state !== 16'h0001 || timeout !== 1'b1 || pin_tries_left !== 2'd3) begin n_err++; $display("FAIL to_fire got %h/%b/%0d exp 0001/1/3", current_state, timeout, pin_tries_left); end
        n_vec++;
        tick();
        if (timeout !== 1'b0) begin n_err++; $display("FAIL to_pulse got %b exp 0", timeout); end
        n_vec++;
        do_reset();
        goto_menu();
        usr_input = 2'b00;
        repeat (7) tick();
        press();
        if (current_state !== 16'h0010 || timeout !== 1'b0) begin n_err++; $display("FAIL to_restart got %h/%b exp 0010/0", current_state, timeout); end
        n_vec++;
        repeat (7) tick();
        if (current_state !== 16'h0010 || timeout !== 1'b0) begin n_err++; $display("FAIL to_restart_hold got %h/%b exp 0010/0", current_state, timeout); end
        n_vec++;
        tick();
        if (current_state !== 16'h0001 || timeout !== 1'b1) begin n_err++; $display("FAIL to_restart_fire got %h/%b exp 0001/1", current_state, timeout); end
        n_vec++;
    endtask

    task automatic test_reset_mid_verify();
        do_reset();
        press(); press();
        if (busy !== 1'b1) begin n_err++; $display("FAIL rmv_busy got %b exp 1", busy); end
        n_vec++;
        rst = 1'b1; tick(); rst = 1'b0;
        respond(1'b1);
        if (current_state !== 16'h0001 || busy !== 1'b0 || vreq !== 1'b0) begin n_err++; $display("FAIL rmv_drop got %h/%b/%b exp 0001/0/0", current_state, busy, vreq); end
        n_vec++;
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_lockout();
        test_withdraw();
        test_convert();
        test_transfer();
        test_abort_race();
        test_timeout();
        test_reset_mid_verify();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/atm_session_ctrl.md
ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle cycles allowed in any non-IDLE state before the session is dropped.
REQ-002 SHALL have parameter MAX_PIN_TRIES, default 3: wrong-PIN attempts allowed before lockout (range 1-3).
REQ-003 SHALL have parameter HOLD_CYCLES, default 4: dwell time in SUCCESS/ERROR.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port ready, input, 1: one-cycle input-complete strobe from the keypad datapath.
REQ-007 SHALL have port status_code, input, 4: keypad status; 4'b0111 = EXIT.
REQ-008 SHALL have port usr_input, input, 2: menu choice; 00 balance, 01 convert, 10 withdraw, 11 transfer.
REQ-009 SHALL have port vdone, input, 1: verifier response strobe.
REQ-010 SHALL have port vok, input, 1: verifier result, qualified by vdone.
REQ-011 SHALL have port current_state, output, 16: one-hot session state, using the codebase encodings.
REQ-012 SHALL have port input_style, output, 4: keypad mode, using the codebase encodings.
REQ-013 SHALL have port vreq, output, 1: one-cycle verify request.
REQ-014 SHALL have port vkind, output, 2: what to verify; 00 account, 01 PIN, 10 amount; valid with vreq.
REQ-015 SHALL have port busy, output, 1: high while awaiting vdone.
REQ-016 SHALL have port locked, output, 1: PIN lockout flag.
REQ-017 SHALL have port timeout, output, 1: one-cycle pulse when the session times out.
REQ-018 SHALL have port pin_tries_left, output, 2: remaining PIN attempts.

Function
REQ-019 SHALL treat event = ready && !busy; ready SHALL be ignored while busy.
REQ-020 SHALL take abort = status_code changing from non-EXIT to EXIT (registered edge detect); a sustained EXIT SHALL NOT re-trigger.
REQ-021 On abort, from any state, the next state SHALL be IDLE; busy SHALL clear; a pending vdone SHALL be discarded; abort SHALL have priority over event, vdone and timeout.
REQ-022 SHALL follow these event transitions:
- IDLE->ACC_NUM
- ACC_NUM->verify account
- PIN_INPUT->verify PIN
- MENU->SHOW_BALANCES, SELECT_CURRENCY_CONVERT_1, SELECT_AMOUNT_WITHDRAW or TRANSFER, per usr_input 00/01/10/11
- SHOW_BALANCES->MENU
- CONVERT_1->CONVERT_2
- CONVERT_2->SUCCESS
- WITHDRAW amount->verify amount
- TRANSFER->verify account
- SELECT_CURRENCY_TRANSFER->SELECT_AMOUNT_TRANSFER
- SELECT_AMOUNT_TRANSFER->verify amount
REQ-023 Verify: on the event cycle+1, vreq SHALL be 1 for exactly one cycle with vkind set; busy SHALL rise the same cycle; current_state SHALL be unchanged.
REQ-024 While busy, the first vdone SHALL clear busy and select the next state on the following edge.
- Account ok: ACC_NUM->PIN_INPUT; TRANSFER->SELECT_CURRENCY_TRANSFER.
- Amount ok: ->SUCCESS.
- Account or amount fail: ->ERROR.
- vdone while not busy SHALL be ignored.
REQ-025 PIN ok SHALL go to MENU and reload pin_tries_left=MAX_PIN_TRIES.
REQ-026 PIN fail SHALL decrement pin_tries_left; if the result is 0, the next state SHALL be ERROR and locked SHALL be set; otherwise the state SHALL stay PIN_INPUT.
REQ-027 While locked=1, IDLE SHALL ignore events; locked SHALL clear only on rst.
REQ-028 SUCCESS and ERROR SHALL each last HOLD_CYCLES cycles and ignore events. Exit: SUCCESS->MENU; ERROR->IDLE.
REQ-029 A timer SHALL count cycles in non-IDLE, non-busy, non-SUCCESS/ERROR states; it SHALL clear on any event or state change; it SHALL freeze while busy.
- At TIMEOUT_CYCLES: next state IDLE, timeout pulses 1 cycle, pin_tries_left reloads.
REQ-030 input_style SHALL be a combinational function of current_state:
- SINGLE_KEY (0001): IDLE, SHOW_BALANCES, SUCCESS, ERROR.
- ACC_NUMBER (0010): ACC_NUM, TRANSFER.
- PIN_NUMBER (0011): PIN_INPUT.
- MENU_SELECTION (0100): MENU.
- CURRENCY_TYPE (0101): CONVERT_1, CONVERT_2, SELECT_CURRENCY_TRANSFER.
- CURRENCY_AMOUNT (0110): SELECT_AMOUNT_WITHDRAW, SELECT_AMOUNT_TRANSFER.
REQ-031 current_state SHALL be exactly one-hot at all times after reset.
REQ-032 Entering IDLE by any path SHALL reload pin_tries_left unless locked.

Reset
REQ-033 rst SHALL set:
- current_state=IDLE (16'h0001), input_style=0001
- vreq=0, vkind=00, busy=0, timeout=0
- locked=0, pin_tries_left=MAX_PIN_TRIES
- timer=0, and the EXIT edge-detect register as if status_code were non-EXIT.
REQ-034 rst asserted mid-verify SHALL drop the transaction; a vdone in the first cycle after rst SHALL be ignored.

Verification
REQ-035 Happy path: ready in IDLE, ACC_NUM; ready -> vreq=1, vkind=00; vdone/vok=1 -> PIN_INPUT; ready -> vreq with vkind=01; vok=1 -> MENU (16'h0008), pin_tries_left=3.
REQ-036 Lockout: 3 PIN attempts each vok=0 -> pin_tries_left 2,1,0; ERROR for 4 cycles, then IDLE with locked=1; further ready in IDLE -> state stays 16'h0001.
REQ-037 Withdraw: MENU, usr_input=10, ready -> SELECT_AMOUNT_WITHDRAW with input_style=0110; ready -> vkind=10; vok=0 -> ERROR, then IDLE after 4 cycles.
REQ-038 Abort race: busy in TRANSFER; status_code 1000->0111 in the same cycle as vdone/vok=1 -> IDLE, busy=0, no SELECT_CURRENCY_TRANSFER; EXIT held 10 cycles -> no further effect.
REQ-039 Timeout: TIMEOUT_CYCLES=8, in MENU with no ready for 8 cycles -> timeout=1 for one cycle, state IDLE; a ready at cycle 7 SHALL restart the count.
